// File: rtl/paillier_operand_loader.sv
// Streams five RSA-width operands (m, r, n, exp_n, g) in from a valid/ready word
// stream, fires a one-cycle go to the encryption core, then waits for done.
module paillier_operand_loader #(
    parameter int unsigned RSA_WIDTH   = 4096,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned DATA_NUMBER = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [RSA_WIDTH-1:0]  m,
    output logic [RSA_WIDTH-1:0]  r,
    output logic [RSA_WIDTH-1:0]  n,
    output logic [RSA_WIDTH-1:0]  exp_n,
    output logic [RSA_WIDTH-1:0]  g,
    output logic                  go,
    input  logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned NUM_OPS = 5;
    localparam int unsigned CNT_W   = (DATA_NUMBER > 1) ? $clog2(DATA_NUMBER) : 1;
    localparam int unsigned IDX_W   = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_NUMBER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RSA_WIDTH-1:0] ops_q [NUM_OPS];
    logic [RSA_WIDTH-1:0] ops_d [NUM_OPS];
    logic                 ready_q, ready_d;
    logic                 go_q, go_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 final_word;

    // Next-state, operand assembly and framing check
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ops_d      = ops_q;
        err_d      = err_q;
        accept     = s_valid && ready_q;
        final_word = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

        case (state_q)
            LOAD: begin
                if (accept) begin
                    // s_last must coincide exactly with the last word of g
                    if (s_last != final_word) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                        idx_d = '0;
                    end else begin
                        ops_d[idx_q][cnt_q*DATA_WIDTH +: DATA_WIDTH] = s_data;
                        if (final_word) begin
                            state_d = FIRE;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            FIRE: state_d = WAIT;
            WAIT: begin
                if (done) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = LOAD;
        endcase

        // clr overrides handshake and done
        if (clr) begin
            state_d = LOAD;
            cnt_d   = '0;
            idx_d   = '0;
            err_d   = 1'b0;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                ops_d[i] = '0;
            end
        end

        ready_d = (state_d == LOAD);
        go_d    = (state_d == FIRE);
        busy_d  = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                ops_q[i] <= ops_d[i];
            end
        end
    end

    assign s_ready = ready_q;
    assign go      = go_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign m       = ops_q[0];
    assign r       = ops_q[1];
    assign n       = ops_q[2];
    assign exp_n   = ops_q[3];
    assign g       = ops_q[4];

endmodule

// File: tb/tb_paillier_operand_loader.sv
// Directed bench for paillier_operand_loader: frame vectors from a table plus
// hand-written sequences for stall, done-in-LOAD, clr and mid-frame reset.
module tb_paillier_operand_loader;

    localparam int unsigned RW = 4096;
    localparam int unsigned DW = 128;
    localparam int unsigned DN = 32;
    localparam int          NW = 5 * DN;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [RW-1:0] m, r, n, exp_n, g;
    logic          go;
    logic          done;
    logic          busy;
    logic          err;

    paillier_operand_loader #(
        .RSA_WIDTH  (RW),
        .DATA_WIDTH (DW),
        .DATA_NUMBER(DN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m      (m),
        .r      (r),
        .n      (n),
        .exp_n  (exp_n),
        .g      (g),
        .go     (go),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int base;
        bit gaps;
        int last_at;   // index carrying s_last; -1 means s_last never set
        bit exp_go;
        bit exp_err;
    } vec_t;

    int            checks;
    int            errors;
    int            go_cnt;
    logic [RW-1:0] exp_op [5];

    always @(negedge clk) if (go === 1'b1) go_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_op(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < int'(DN); k++) begin
                if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s word %0d: got %h expected %h", name, k,
                             act[k*DW +: DW], exp[k*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    task automatic make_exp(input int base);
        for (int o = 0; o < 5; o++)
            for (int k = 0; k < int'(DN); k++)
                exp_op[o][k*DW +: DW] = DW'(base + o*int'(DN) + k);
    endtask

    task automatic zero_exp();
        for (int o = 0; o < 5; o++) exp_op[o] = '0;
    endtask

    task automatic check_ops(input string tag);
        chk_op({tag, "_m"},     m,     exp_op[0]);
        chk_op({tag, "_r"},     r,     exp_op[1]);
        chk_op({tag, "_n"},     n,     exp_op[2]);
        chk_op({tag, "_exp_n"}, exp_n, exp_op[3]);
        chk_op({tag, "_g"},     g,     exp_op[4]);
    endtask

    // Present one word from a negedge, hold until accepted on a posedge
    task automatic send_word(input logic [DW-1:0] d, input logic l, input bit gap);
        int wait_n;
        @(negedge clk);
        if (gap && $urandom_range(0, 1) == 1) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        wait_n  = 0;
        while (!s_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got s_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_range(input int base, input int from, input int to,
                              input int last_at, input bit gaps);
        for (int i = from; i <= to; i++)
            send_word(DW'(base + i), (i == last_at), gaps);
    endtask

    // go must appear exactly one cycle after the final handshake, then WAIT
    task automatic fire_checks(input string tag);
        @(negedge clk);
        chk({tag, "_go_fire"},    32'(go),      32'd1);
        chk({tag, "_ready_fire"}, 32'(s_ready), 32'd0);
        chk({tag, "_busy_fire"},  32'(busy),    32'd1);
        @(negedge clk);
        chk({tag, "_go_wait"},    32'(go),      32'd0);
        chk({tag, "_busy_wait"},  32'(busy),    32'd1);
        chk({tag, "_go_count"},   32'(go_cnt),  32'd1);
        check_ops(tag);
    endtask

    task automatic pulse_done(input string tag);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk({tag, "_ready_done"}, 32'(s_ready), 32'd1);
        chk({tag, "_busy_done"},  32'(busy),    32'd0);
        check_ops({tag, "_kept"});
    endtask

    vec_t vecs [6];

    initial begin
        checks  = 0;
        errors  = 0;
        go_cnt  = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        done    = 1'b0;

        vecs[0] = '{0,    1'b0, NW-1, 1'b1, 1'b0};
        vecs[1] = '{0,    1'b1, NW-1, 1'b1, 1'b0};
        vecs[2] = '{1000, 1'b0, 40,   1'b0, 1'b1};
        vecs[3] = '{2000, 1'b0, NW-1, 1'b1, 1'b1};
        vecs[4] = '{3000, 1'b1, -1,   1'b0, 1'b1};
        vecs[5] = '{4000, 1'b1, NW-1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        zero_exp();
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_go",    32'(go),      32'd0);
        chk("rst_err",   32'(err),     32'd0);
        check_ops("rst");

        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            go_cnt = 0;
            make_exp(vecs[v].base);
            send_range(vecs[v].base, 0, (vecs[v].last_at >= 0) ? vecs[v].last_at : NW-1,
                       vecs[v].last_at, vecs[v].gaps);
            if (vecs[v].exp_go) begin
                fire_checks(tag);
                if (v == 0) begin
                    chk("m_low_word", 32'(m[DW-1:0]),     32'd0);
                    chk("g_top_word", 32'(g[RW-1 -: DW]), 32'd159);
                end
                chk({tag, "_err"}, 32'(err), 32'(vecs[v].exp_err));
                pulse_done(tag);
            end else begin
                repeat (3) @(negedge clk);
                chk({tag, "_go_count"}, 32'(go_cnt),  32'd0);
                chk({tag, "_busy"},     32'(busy),    32'd0);
                chk({tag, "_ready"},    32'(s_ready), 32'd1);
                chk({tag, "_err"},      32'(err),     32'(vecs[v].exp_err));
            end
        end

        // done in LOAD mid-frame and a long stall must not disturb the frame
        go_cnt = 0;
        make_exp(7000);
        send_range(7000, 0, 29, NW-1, 1'b0);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (40) @(negedge clk);
        chk("stall_ready",    32'(s_ready), 32'd1);
        chk("stall_busy",     32'(busy),    32'd0);
        chk("stall_go_count", 32'(go_cnt),  32'd0);
        send_range(7000, 30, NW-1, NW-1, 1'b0);
        fire_checks("midload");
        chk("midload_err_sticky", 32'(err), 32'd1);

        // clr while waiting on the core
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        zero_exp();
        chk("clr_ready", 32'(s_ready), 32'd1);
        chk("clr_busy",  32'(busy),    32'd0);
        chk("clr_go",    32'(go),      32'd0);
        chk("clr_err",   32'(err),     32'd0);
        check_ops("clr");

        // asynchronous reset after word 100 of a frame
        send_range(8000, 0, 100, NW-1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(s_ready), 32'd1);
        chk("arst_busy",  32'(busy),    32'd0);
        chk("arst_go",    32'(go),      32'd0);
        check_ops("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 32'(s_ready), 32'd1);
        go_cnt = 0;
        make_exp(9000);
        send_range(9000, 0, NW-1, NW-1, 1'b0);
        fire_checks("after_rst");
        chk("after_rst_err", 32'(err), 32'd0);
        pulse_done("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
